// File: rtl/avalon_aes_master.sv
// Avalon-MM initiator for the AES register file: loads key/message, starts, polls DONE, then reads the plaintext.
// Outputs decode combinationally from registered state; each command is held until accepted (WAITREQUEST low).
module avalon_aes_master #(
   parameter int READ_LATENCY = 1,
   parameter int POLL_LIMIT   = 1024,
   parameter int POLL_GAP     = 0
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         GO,
   input  logic [127:0] KEY,
   input  logic [127:0] MSG_EN,
   output logic [127:0] MSG_DE,
   output logic         BUSY,
   output logic         DONE,
   output logic         ERR,
   output logic         AVL_READ,
   output logic         AVL_WRITE,
   output logic         AVL_CS,
   output logic [3:0]   AVL_BYTE_EN,
   output logic [3:0]   AVL_ADDR,
   output logic [31:0]  AVL_WRITEDATA,
   input  logic [31:0]  AVL_READDATA,
   input  logic         AVL_WAITREQUEST
);

   localparam int PW = $clog2(POLL_LIMIT + 1);
   localparam int LW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY);
   localparam int GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
   localparam logic [PW-1:0] PLIM     = PW'(POLL_LIMIT);
   localparam logic [LW-1:0] LAST_LAT = LW'(READ_LATENCY - 1);
   localparam logic [GW-1:0] LAST_GAP = GW'(POLL_GAP - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_WR, S_POLL_RQ, S_POLL_WT, S_GAP, S_RD_RQ, S_RD_WT, S_STOP, S_FIN
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      idx_q;
   logic [PW-1:0]   pcnt_q;
   logic [LW-1:0]   lat_q;
   logic [GW-1:0]   gap_q;
   logic [127:0]    key_q;
   logic [127:0]    msg_q;
   logic [127:0]    msg_de_q;
   logic            err_q;
   logic            accept;
   logic            lat_last;

   assign accept      = (AVL_READ | AVL_WRITE) & ~AVL_WAITREQUEST;
   assign lat_last    = (lat_q == LAST_LAT);
   assign AVL_CS      = AVL_READ | AVL_WRITE;
   assign AVL_BYTE_EN = 4'hF;
   assign BUSY        = (state_q != S_IDLE) && (state_q != S_FIN);
   assign DONE        = (state_q == S_FIN);
   assign ERR         = err_q;
   assign MSG_DE      = msg_de_q;

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      AVL_READ      = 1'b0;
      AVL_WRITE     = 1'b0;
      AVL_ADDR      = 4'd0;
      AVL_WRITEDATA = 32'd0;
      case (state_q)
         S_IDLE: if (GO) state_d = S_WR;
         S_WR: begin
            AVL_WRITE = 1'b1;
            if (idx_q < 4'd4) begin
               AVL_ADDR      = idx_q;
               AVL_WRITEDATA = key_q[{idx_q[1:0], 5'b0} +: 32];
            end else if (idx_q < 4'd8) begin
               AVL_ADDR      = idx_q;
               AVL_WRITEDATA = msg_q[{idx_q[1:0], 5'b0} +: 32];
            end else if (idx_q == 4'd8) begin
               AVL_ADDR      = 4'd15;   // clear DONE before raising START
               AVL_WRITEDATA = 32'd0;
            end else begin
               AVL_ADDR      = 4'd14;
               AVL_WRITEDATA = 32'd1;
            end
            if (accept && idx_q == 4'd9) state_d = S_POLL_RQ;
         end
         S_POLL_RQ: begin
            AVL_READ = 1'b1;
            AVL_ADDR = 4'd15;
            if (accept) state_d = S_POLL_WT;
         end
         S_POLL_WT: begin
            if (lat_last) begin
               if (AVL_READDATA[0])     state_d = S_RD_RQ;
               else if (pcnt_q == PLIM) state_d = S_STOP;
               else if (POLL_GAP > 0)   state_d = S_GAP;
               else                     state_d = S_POLL_RQ;
            end
         end
         S_GAP: if (gap_q == LAST_GAP) state_d = S_POLL_RQ;
         S_RD_RQ: begin
            AVL_READ = 1'b1;
            AVL_ADDR = {2'b10, idx_q[1:0]};
            if (accept) state_d = S_RD_WT;
         end
         S_RD_WT: begin
            if (lat_last) state_d = (idx_q == 4'd3) ? S_STOP : S_RD_RQ;
         end
         S_STOP: begin
            AVL_WRITE = 1'b1;
            AVL_ADDR  = 4'd14;
            if (accept) state_d = S_FIN;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         idx_q    <= 4'd0;
         pcnt_q   <= '0;
         lat_q    <= '0;
         gap_q    <= '0;
         key_q    <= 128'd0;
         msg_q    <= 128'd0;
         msg_de_q <= 128'd0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (GO) begin
               key_q <= KEY;
               msg_q <= MSG_EN;
               err_q <= 1'b0;
               idx_q <= 4'd0;
            end
            S_WR: if (accept) begin
               idx_q <= (idx_q == 4'd9) ? 4'd0 : idx_q + 4'd1;
               if (idx_q == 4'd9) pcnt_q <= '0;
            end
            S_POLL_RQ: if (accept) begin
               pcnt_q <= pcnt_q + 1'b1;
               lat_q  <= '0;
            end
            S_POLL_WT: begin
               lat_q <= lat_q + 1'b1;
               if (lat_last) begin
                  gap_q <= '0;
                  idx_q <= 4'd0;
                  if (!AVL_READDATA[0] && pcnt_q == PLIM) err_q <= 1'b1;
               end
            end
            S_GAP:   gap_q <= gap_q + 1'b1;
            S_RD_RQ: if (accept) lat_q <= '0;
            S_RD_WT: begin
               lat_q <= lat_q + 1'b1;
               if (lat_last) begin
                  msg_de_q[{idx_q[1:0], 5'b0} +: 32] <= AVL_READDATA;
                  idx_q <= idx_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_aes_master.sv
// Directed bench: two initiators (default and POLL_LIMIT=4) share one register-file slave model.
module tb_avalon_aes_master;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic         RESET;
   logic         go0, go1;
   logic [127:0] key, msg;
   logic [127:0] msg_de0, msg_de1;
   logic         busy0, busy1, done0, done1, err0, err1;
   logic         rd0, rd1, wr0, wr1, cs0, cs1;
   logic [3:0]   be0, be1, addr0, addr1;
   logic [31:0]  wd0, wd1;
   logic [31:0]  rdata;
   logic         waitreq;
   logic         sel;

   avalon_aes_master u_dut0 (
      .CLK(CLK), .RESET(RESET), .GO(go0), .KEY(key), .MSG_EN(msg), .MSG_DE(msg_de0),
      .BUSY(busy0), .DONE(done0), .ERR(err0), .AVL_READ(rd0), .AVL_WRITE(wr0), .AVL_CS(cs0),
      .AVL_BYTE_EN(be0), .AVL_ADDR(addr0), .AVL_WRITEDATA(wd0),
      .AVL_READDATA(rdata), .AVL_WAITREQUEST(waitreq));

   avalon_aes_master #(.POLL_LIMIT(4)) u_dut1 (
      .CLK(CLK), .RESET(RESET), .GO(go1), .KEY(key), .MSG_EN(msg), .MSG_DE(msg_de1),
      .BUSY(busy1), .DONE(done1), .ERR(err1), .AVL_READ(rd1), .AVL_WRITE(wr1), .AVL_CS(cs1),
      .AVL_BYTE_EN(be1), .AVL_ADDR(addr1), .AVL_WRITEDATA(wd1),
      .AVL_READDATA(rdata), .AVL_WAITREQUEST(waitreq));

   logic [127:0] m_msg_de;
   logic         m_busy, m_done, m_err, m_rd, m_wr, m_cs;
   logic [3:0]   m_be, m_addr;
   logic [31:0]  m_wd;
   assign m_msg_de = sel ? msg_de1 : msg_de0;
   assign m_busy   = sel ? busy1 : busy0;
   assign m_done   = sel ? done1 : done0;
   assign m_err    = sel ? err1 : err0;
   assign m_rd     = sel ? rd1 : rd0;
   assign m_wr     = sel ? wr1 : wr0;
   assign m_cs     = sel ? cs1 : cs0;
   assign m_be     = sel ? be1 : be0;
   assign m_addr   = sel ? addr1 : addr0;
   assign m_wd     = sel ? wd1 : wd0;

   // Slave model and transaction monitor
   int           cyc = 0;
   logic [31:0]  mem [16];
   logic [3:0]   wlog_a [32];
   logic [31:0]  wlog_d [32];
   int           wn = 0, poll_n = 0, rd8_n = 0, done_n = 0, done_cyc = 0, first_wr_cyc = 0;
   int           unstable = 0, proto_bad = 0, stall_n = 0, stall_cnt = 0;
   logic         prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
   logic [3:0]   prev_addr = 4'd0;
   logic [31:0]  prev_wd = 32'd0;
   bit           rnd_en = 1'b0, clr = 1'b1;
   logic [127:0] plain = 128'd0;
   int           done_at = 1;

   assign waitreq = (stall_cnt != 0);

   always @(posedge CLK) begin
      cyc        <= cyc + 1;
      prev_stall <= (m_rd | m_wr) && waitreq;
      prev_addr  <= m_addr;
      prev_wd    <= m_wd;
      prev_rd    <= m_rd;
      prev_wr    <= m_wr;
      if (clr) begin
         wn <= 0; poll_n <= 0; rd8_n <= 0; done_n <= 0; unstable <= 0; proto_bad <= 0; stall_n <= 0;
      end else begin
         if (prev_stall && (m_addr !== prev_addr || m_wd !== prev_wd || m_rd !== prev_rd || m_wr !== prev_wr))
            unstable <= unstable + 1;
         if (m_cs !== (m_rd | m_wr) || m_be !== 4'hF || (m_done && m_busy))
            proto_bad <= proto_bad + 1;
         if (m_done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
         end
         if (m_rd | m_wr) begin
            if (waitreq) begin
               stall_cnt <= stall_cnt - 1;
               stall_n   <= stall_n + 1;
            end else begin
               stall_cnt <= rnd_en ? int'($urandom_range(0, 3)) : 0;
               if (m_wr) begin
                  mem[m_addr] <= m_wd;
                  if (wn < 32) begin
                     wlog_a[wn] <= m_addr;
                     wlog_d[wn] <= m_wd;
                  end
                  if (wn == 0) first_wr_cyc <= cyc;
                  wn <= wn + 1;
               end else if (m_addr == 4'd15) begin
                  poll_n <= poll_n + 1;
                  rdata  <= (done_at != 0 && poll_n + 1 >= done_at) ? 32'd1 : 32'd0;
               end else if (m_addr >= 4'd8 && m_addr <= 4'd11) begin
                  rd8_n <= rd8_n + 1;
                  rdata <= plain[(int'(m_addr) - 8) * 32 +: 32];
               end else begin
                  rdata <= mem[m_addr];
               end
            end
         end
      end
   end

   int n_tests = 0, n_fail = 0;
   int go_cyc = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_go(input logic v);
      if (sel) go1 = v;
      else     go0 = v;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_msg_de"}, m_msg_de, 128'd0);
      chk({tag, "_flags"}, {m_busy, m_done, m_err, m_rd, m_wr, m_cs}, 6'd0);
      chk({tag, "_addr"}, m_addr, 4'd0);
      chk({tag, "_wdata"}, m_wd, 32'd0);
      chk({tag, "_byte_en"}, m_be, 4'hF);
   endtask

   task automatic start_op(input logic [127:0] k, input logic [127:0] m, input logic [127:0] p, input int dat);
      @(negedge CLK);
      clr = 1'b1; key = k; msg = m; plain = p; done_at = dat;
      @(negedge CLK);
      clr = 1'b0;
      set_go(1'b1);
      go_cyc = cyc;
      @(negedge CLK);
      set_go(1'b0);
      key = ~k;            // inputs must have been latched at GO
      msg = ~m;
      chk("busy_cycle1", m_busy, 1'b1);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_n == 0 && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      chk({tag, "_done_seen"}, done_n != 0, 1'b1);
      repeat (30) @(negedge CLK);
   endtask

   task automatic chk_writes(input string tag, input logic [127:0] k, input logic [127:0] m);
      chk({tag, "_wcount"}, wn, 11);
      for (int i = 0; i < 11; i++) begin
         logic [3:0]  ea;
         logic [31:0] ed;
         if (i < 4)       begin ea = 4'(i); ed = k[i*32 +: 32]; end
         else if (i < 8)  begin ea = 4'(i); ed = m[(i-4)*32 +: 32]; end
         else if (i == 8) begin ea = 4'd15; ed = 32'd0; end
         else if (i == 9) begin ea = 4'd14; ed = 32'd1; end
         else             begin ea = 4'd14; ed = 32'd0; end
         chk($sformatf("%s_w%0d", tag, i), {wlog_a[i], wlog_d[i]}, {ea, ed});
      end
   endtask

   localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] M0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] P1 = 128'hdeadbeef0123456789abcdeffedcba98;
   localparam logic [127:0] P2 = 128'h1111111122222222333333334444444f;

   initial begin
      RESET = 1'b1; go0 = 1'b0; go1 = 1'b0; sel = 1'b0; key = '0; msg = '0;
      repeat (3) @(negedge CLK);
      chk_reset("reset0");
      sel = 1'b1;
      chk_reset("reset1");
      sel = 1'b0;
      RESET = 1'b0;

      // Nominal run
      start_op(K0, M0, P0, 1);
      wait_done("nom");
      chk("nom_done_cycle", done_cyc - go_cyc, 22);
      chk("nom_first_write_cycle", first_wr_cyc - go_cyc, 1);
      chk("nom_w0_literal", {wlog_a[0], wlog_d[0]}, {4'd0, 32'h0c0d0e0f});
      chk_writes("nom", K0, M0);
      chk("nom_polls", poll_n, 1);
      chk("nom_reads", rd8_n, 4);
      chk("nom_msg_de", m_msg_de, P0);
      chk("nom_err", m_err, 1'b0);
      chk("nom_done_pulses", done_n, 1);
      chk("nom_protocol", proto_bad, 0);
      chk("nom_busy_after", m_busy, 1'b0);

      // DONE on the 5th poll
      start_op(M0, K0, P1, 5);
      wait_done("dly");
      chk("dly_polls", poll_n, 5);
      chk("dly_done_cycle", done_cyc - go_cyc, 30);
      chk("dly_msg_de", m_msg_de, P1);

      // GO while busy is ignored
      start_op(K0, M0, P0, 1);
      repeat (4) @(negedge CLK);
      set_go(1'b1);
      @(negedge CLK);
      set_go(1'b0);
      wait_done("bgo");
      chk("bgo_done_cycle", done_cyc - go_cyc, 22);
      chk("bgo_done_pulses", done_n, 1);
      chk("bgo_wcount", wn, 11);

      // Random stalls
      rnd_en = 1'b1;
      start_op(P1, P0, P2, 2);
      wait_done("wrq");
      rnd_en = 1'b0;
      chk_writes("wrq", P1, P0);
      chk("wrq_stalls_seen", stall_n > 0, 1'b1);
      chk("wrq_unstable", unstable, 0);
      chk("wrq_polls", poll_n, 2);
      chk("wrq_reads", rd8_n, 4);
      chk("wrq_msg_de", m_msg_de, P2);
      chk("wrq_protocol", proto_bad, 0);

      // Reset during polling
      begin
         int n = 0;
         start_op(K0, M0, P0, 0);
         while (poll_n < 2 && n < 200) begin
            @(negedge CLK);
            n++;
         end
         chk("rst_poll_reached", poll_n >= 2, 1'b1);
         RESET = 1'b1;
         @(negedge CLK);
         chk_reset("rst_mid");
         RESET = 1'b0;
         repeat (20) @(negedge CLK);
         chk("rst_no_cleanup_write", wn, 10);
         chk("rst_no_done", done_n, 0);
      end
      start_op(K0, M0, P0, 1);
      wait_done("rst_after");
      chk("rst_after_done_cycle", done_cyc - go_cyc, 22);
      chk("rst_after_msg_de", m_msg_de, P0);

      // Timeout on the POLL_LIMIT=4 instance
      sel = 1'b1;
      start_op(K0, M0, P1, 1);
      wait_done("to_pre");
      chk("to_pre_msg_de", m_msg_de, P1);
      start_op(M0, K0, P2, 0);
      wait_done("to");
      chk("to_polls", poll_n, 4);
      chk("to_err_sticky", m_err, 1'b1);
      chk("to_reads", rd8_n, 0);
      chk("to_done_cycle", done_cyc - go_cyc, 20);
      chk("to_done_pulses", done_n, 1);
      chk("to_msg_de_kept", m_msg_de, P1);
      chk_writes("to", M0, K0);
      start_op(K0, M0, P0, 1);
      chk("to_err_cleared", m_err, 1'b0);
      wait_done("to_post");
      chk("to_post_msg_de", m_msg_de, P0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/avalon_aes_master.md
Name: avalon_aes_master

Overview:
Avalon-MM initiator that drives the AES decryption core's 16x32 register file.
- On a GO pulse it writes the 128-bit key and the encrypted message.
- It then clears DONE and sets START.
- It polls the DONE register until bit 0 is set, then reads back the 128-bit decrypted message and clears START.
- It sits between an on-chip controller (or test harness) and the AES slave interface, replacing the NIOS software driver for hardware-only runs.

Parameters:
- READ_LATENCY, 1, cycles from read acceptance to AVL_READDATA valid; the slave registers read data, so 1.
- POLL_LIMIT, 1024, maximum number of DONE-register polls before the operation aborts with ERR.
- POLL_GAP, 0, idle cycles inserted between consecutive DONE polls.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous reset, active-high
- GO  in  1  start request; sampled only in IDLE
- KEY  in  128  AES key; word i = KEY[32i+31:32i] goes to address i
- MSG_EN  in  128  encrypted message; word i goes to address 4+i
- MSG_DE  out  128  decrypted message; word i is read from address 8+i
- BUSY  out  1  high while an operation is in progress
- DONE  out  1  one-cycle pulse on completion
- ERR  out  1  poll timeout flag; sticky until next accepted GO
- AVL_READ  out  1  Avalon read
- AVL_WRITE  out  1  Avalon write
- AVL_CS  out  1  chip select; high whenever AVL_READ or AVL_WRITE is high
- AVL_BYTE_EN  out  4  always 4'hF
- AVL_ADDR  out  4  word address
- AVL_WRITEDATA  out  32  write data
- AVL_READDATA  in  32  read data
- AVL_WAITREQUEST  in  1  slave stall; tie low for the AES slave

Behaviour:
- Reset values: MSG_DE=0, BUSY=0, DONE=0, ERR=0, AVL_READ=0, AVL_WRITE=0, AVL_CS=0, AVL_ADDR=0, AVL_WRITEDATA=0, AVL_BYTE_EN=4'hF; FSM=IDLE; counters=0.
- Reset mid-operation: abandon the transfer immediately and return to reset values; no cleanup write is issued.
- Transfer acceptance: a command is accepted on a cycle where READ/WRITE=1 and AVL_WAITREQUEST=0. While WAITREQUEST=1, ADDR, WRITEDATA, READ and WRITE are held stable.
- Read data: captured exactly READ_LATENCY cycles after acceptance.
- KEY and MSG_EN: latched into internal registers when GO is accepted, so inputs may change afterwards.
- FSM states:
  - IDLE: BUSY=0. On GO=1, latch inputs, clear ERR, set BUSY=1 next cycle, go to WR with idx=0. GO while not IDLE is ignored.
  - WR: one write per accepted cycle, idx 0..9:
    - idx 0-3: ADDR=idx, data=key word idx.
    - idx 4-7: ADDR=idx, data=msg word idx-4.
    - idx 8: ADDR=15, data=0 (clear DONE).
    - idx 9: ADDR=14, data=1 (START).
    - After idx 9 is accepted, go to POLL_RQ with pcnt=0.
  - POLL_RQ: read ADDR=15; on acceptance, pcnt++ and go to POLL_WT.
  - POLL_WT: wait READ_LATENCY cycles, then sample data.
    - Bit0=1: go to RD_RQ with idx=0.
    - Else if pcnt==POLL_LIMIT: set ERR=1 and go to STOP.
    - Else: go to GAP (POLL_GAP cycles; skipped if 0), then POLL_RQ.
  - RD_RQ / RD_WT: read ADDR=8+idx and capture into MSG_DE word idx, for idx 0..3, then go to STOP.
  - STOP: write ADDR=14, data=0 (clear START); on acceptance go to FIN.
  - FIN: DONE=1 for one cycle, BUSY=0 in the same cycle, then IDLE.
- MSG_DE update rules:
  - Each word updates only on its own capture and holds until overwritten by the next operation.
  - On ERR, MSG_DE keeps its previous contents.
- Timing with WAITREQUEST=0, READ_LATENCY=1, DONE set at first poll, GO high in cycle 0:
  - writes in cycles 1-10;
  - poll in cycles 11-12;
  - reads in cycles 13-20;
  - STOP in cycle 21;
  - DONE=1 in cycle 22.
- Each additional poll adds 2+POLL_GAP cycles.
- Counters: idx is 4 bits. pcnt is wide enough for POLL_LIMIT and does not wrap.
- GO and RESET in the same cycle: RESET wins.

Test Plan:
- Nominal run:
  - Stimulus: slave model with WAITREQUEST=0; KEY=128'h000102030405060708090a0b0c0d0e0f; MSG_EN=128'h69c4e0d86a7b0430d8cdb78070b4c55a; slave sets DONE at the first poll and returns 128'h00112233445566778899aabbccddeeff.
  - Required response: write sequence addr 0..7 with words LSW first (addr0=32'h0c0d0e0f), then addr15=0 and addr14=1; MSG_DE equals 128'h00112233445566778899aabbccddeeff; DONE pulses in cycle 22; ERR=0.
- Delayed done: slave sets DONE on the 5th poll, POLL_GAP=0 -> exactly 5 reads of addr 15; DONE in cycle 30.
- Timeout: POLL_LIMIT=4 and DONE never set -> 4 polls, then ERR=1, addr14=0 written, DONE pulse, no reads of addr 8-11, MSG_DE unchanged.
- Waitrequest: random WAITREQUEST stalls of 0-3 cycles -> ADDR and WRITEDATA stable while stalled; no duplicate or dropped transfer; MSG_DE correct.
- Reset: RESET asserted during the poll phase -> next cycle all outputs at reset values; a subsequent GO completes normally.
- Busy GO: GO pulsed again while BUSY -> ignored; exactly one 22-cycle operation and a single DONE pulse.
